// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Shared types for the rv32i pipeline.
//   rv32i_word     : 32-bit machine word (PCs, instructions, data).
//   fetch_state_t  : instruction-fetch stage state machine encoding.
// -----------------------------------------------------------------------------
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // IDLE  : after reset, no request outstanding
    // FETCH : read request outstanding for pc_q
    // HOLD  : fetched word parked in insn_q while downstream stalls
    // FLUSH : a killed request is still outstanding; target_q is next PC
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the rv32i pipeline. Owns the program counter,
//   issues word reads to instruction memory with a held read/response
//   handshake, presents {pc, insn, valid} to IF/ID, parks a fetched word while
//   the pipeline stalls and discards in-flight fetches on a redirect.
//
// Parameters
//   RESET_PC       PC value after reset
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   stall_i        downstream not accepting this cycle
//   redirect_i     taken branch/jump kills the current fetch
//   redirect_pc_i  new fetch target (valid with redirect_i)
//   imem_read_o    instruction-memory read request (held until imem_resp_i)
//   imem_addr_o    read address (always pc_q)
//   imem_resp_i    single-cycle read-data-valid pulse
//   imem_rdata_i   read data
//   pc_o           PC of the presented instruction
//   insn_o         presented instruction word
//   insn_valid_o   pc_o/insn_o valid this cycle
// -----------------------------------------------------------------------------
module if_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC = 32'h6000_0000
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      stall_i,
    input  logic      redirect_i,
    input  rv32i_word redirect_pc_i,
    output logic      imem_read_o,
    output rv32i_word imem_addr_o,
    input  logic      imem_resp_i,
    input  rv32i_word imem_rdata_i,
    output rv32i_word pc_o,
    output rv32i_word insn_o,
    output logic      insn_valid_o
);

    fetch_state_t state_q, state_d;
    rv32i_word    pc_q, pc_d;
    rv32i_word    insn_q, insn_d;
    rv32i_word    target_q, target_d;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            insn_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            insn_q   <= insn_d;
            target_q <= target_d;
        end
    end

    // Next-state logic. A redirect always wins over stall and response.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        insn_d   = insn_q;
        target_d = target_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
            end

            FETCH: begin
                if (redirect_i) begin
                    if (imem_resp_i) begin
                        // Request already closed: start the target right away.
                        pc_d = redirect_pc_i;
                    end else begin
                        // Request still open: wait it out in FLUSH.
                        target_d = redirect_pc_i;
                        state_d  = FLUSH;
                    end
                end else if (imem_resp_i) begin
                    if (stall_i) begin
                        insn_d  = imem_rdata_i;
                        state_d = HOLD;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end

            FLUSH: begin
                if (imem_resp_i) begin
                    // Killed data is dropped; a same-cycle redirect beats target_q.
                    pc_d    = redirect_i ? redirect_pc_i : target_q;
                    state_d = FETCH;
                end else if (redirect_i) begin
                    target_d = redirect_pc_i;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        imem_read_o  = (state_q == FETCH) || (state_q == FLUSH);
        imem_addr_o  = pc_q;
        pc_o         = pc_q;
        insn_o       = insn_q;
        insn_valid_o = 1'b0;

        if (state_q == FETCH && imem_resp_i) begin
            insn_o       = imem_rdata_i;
            insn_valid_o = !redirect_i;
        end else if (state_q == HOLD) begin
            insn_valid_o = !redirect_i;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import rv32i_types::*;

    localparam rv32i_word P = 32'h6000_0000;

    logic      clk_i = 1'b0;
    logic      rst_ni = 1'b1;
    logic      stall_i = 1'b0;
    logic      redirect_i = 1'b0;
    rv32i_word redirect_pc_i = '0;
    logic      imem_read_o;
    rv32i_word imem_addr_o;
    logic      imem_resp_i = 1'b0;
    rv32i_word imem_rdata_i = '0;
    rv32i_word pc_o;
    rv32i_word insn_o;
    logic      insn_valid_o;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(P)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_read_o   (imem_read_o),
        .imem_addr_o   (imem_addr_o),
        .imem_resp_i   (imem_resp_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .insn_o        (insn_o),
        .insn_valid_o  (insn_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle vector: inputs, then expected outputs (pc_o expected == e_addr).
    typedef struct {
        logic      stall;
        logic      redir;
        rv32i_word rpc;
        logic      resp;
        rv32i_word rdata;
        logic      e_read;
        rv32i_word e_addr;
        logic      e_valid;
        rv32i_word e_insn;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic st, input logic rd, input rv32i_word rpc,
                       input logic rs, input rv32i_word dat,
                       input logic er, input rv32i_word ea,
                       input logic ev, input rv32i_word ei);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rpc; v.resp = rs; v.rdata = dat;
        v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.e_insn = ei;
        tbl.push_back(v);
    endtask

    typedef struct {
        rv32i_word pc;
        rv32i_word insn;
    } exp_t;

    exp_t sb[$];

    // Assert reset, check reset outputs, release between edges so the next
    // negedge starts the IDLE cycle.
    task automatic do_reset();
        stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
        imem_resp_i = 0; imem_rdata_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_read",  {31'd0, imem_read_o},  32'd0);
        chk("rst_addr",  imem_addr_o,           P);
        chk("rst_pc",    pc_o,                  P);
        chk("rst_insn",  insn_o,                32'd0);
        chk("rst_valid", {31'd0, insn_valid_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    // Memory model with fixed latency and random stalls; expected {pc, insn}
    // is queued when the response is driven and retired when IF/ID accepts.
    task automatic stream(input int lat, input int ncyc, input int stall_pct);
        int        cnt = 0;
        int        acc = 0;
        rv32i_word mpc = P;
        exp_t      e;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk_i);
            stall_i    = ($urandom_range(99) < stall_pct);
            redirect_i = 1'b0;
            if (imem_read_o) begin
                chk("stream_addr", imem_addr_o, mpc);
                if (cnt == lat) begin
                    imem_resp_i  = 1'b1;
                    imem_rdata_i = mpc ^ 32'h1357_9BDF;
                    e.pc   = mpc;
                    e.insn = mpc ^ 32'h1357_9BDF;
                    sb.push_back(e);
                    cnt = 0;
                end else begin
                    imem_resp_i = 1'b0;
                    cnt++;
                end
            end else begin
                imem_resp_i = 1'b0;
                cnt = 0;
            end
            #1;
            if (lat == 1 && stall_pct == 0)
                chk("stream_pulse", {31'd0, insn_valid_o}, {31'd0, (c >= 2 && c % 2 == 0)});
            if (insn_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_spurious actual=valid required=no_valid");
                end else begin
                    chk("stream_pc",   pc_o,   sb[0].pc);
                    chk("stream_insn", insn_o, sb[0].insn);
                    if (!stall_i) begin
                        void'(sb.pop_front());
                        mpc += 32'd4;
                        acc++;
                    end
                end
            end
        end
        if (stall_pct == 0)
            chk("stream_count", acc, (ncyc - 1) / (lat + 1));
        else
            chk("stream_progress", {31'd0, acc > 0}, 32'd1);
        stall_i = 0; imem_resp_i = 0;
        sb.delete();
    endtask

    initial begin
        // stall redir rpc resp rdata | read addr valid insn
        row(0,0,'0,0,'0,                     0,P,        0,'0);           // IDLE
        row(0,0,'0,0,'0,                     1,P,        0,'0);           // first read
        row(0,0,'0,1,32'h0000_0013,          1,P,        1,32'h0000_0013);
        row(0,0,'0,0,'0,                     1,P+4,      0,'0);
        row(1,0,'0,1,32'h00A0_0093,          1,P+4,      1,32'h00A0_0093); // stall on resp
        row(1,0,'0,0,'0,                     0,P+4,      1,32'h00A0_0093); // HOLD
        row(1,0,'0,0,'0,                     0,P+4,      1,32'h00A0_0093);
        row(0,0,'0,0,'0,                     0,P+4,      1,32'h00A0_0093); // accepted
        row(0,0,'0,0,'0,                     1,P+8,      0,'0);
        row(0,1,P+32'h100,0,'0,              1,P+8,      0,'0);           // redirect in flight
        row(0,0,'0,0,'0,                     1,P+8,      0,'0);           // FLUSH
        row(0,0,'0,1,32'hDEAD_BEEF,          1,P+8,      0,'0);           // dropped
        row(0,0,'0,0,'0,                     1,P+32'h100,0,'0);
        row(0,0,'0,1,32'h0010_0113,          1,P+32'h100,1,32'h0010_0113);
        row(0,1,P+32'h200,1,32'hDEAD_BEEF,   1,P+32'h104,0,'0);           // redirect + resp
        row(0,0,'0,0,'0,                     1,P+32'h200,0,'0);
        row(1,0,'0,1,32'h0000_0011,          1,P+32'h200,1,32'h0000_0011);
        row(1,1,P+32'h300,0,'0,              0,P+32'h200,0,'0);           // redirect in HOLD
        row(0,0,'0,0,'0,                     1,P+32'h300,0,'0);
        row(0,1,P+32'h400,0,'0,              1,P+32'h300,0,'0);
        row(0,1,P+32'h500,0,'0,              1,P+32'h300,0,'0);           // second redirect
        row(0,0,'0,1,32'hDEAD_BEEF,          1,P+32'h300,0,'0);
        row(0,0,'0,0,'0,                     1,P+32'h500,0,'0);
        row(0,0,'0,1,32'h0000_0022,          1,P+32'h500,1,32'h0000_0022);
        row(0,1,P+32'h600,0,'0,              1,P+32'h504,0,'0);
        row(0,1,P+32'h700,1,32'hDEAD_BEEF,   1,P+32'h504,0,'0);           // FLUSH redirect + resp
        row(0,0,'0,0,'0,                     1,P+32'h700,0,'0);
        row(0,0,'0,1,32'h0000_0033,          1,P+32'h700,1,32'h0000_0033);
        row(0,1,32'hFFFF_FFFC,0,'0,          1,P+32'h704,0,'0);
        row(0,0,'0,1,32'hDEAD_BEEF,          1,P+32'h704,0,'0);
        row(0,0,'0,0,'0,                     1,32'hFFFF_FFFC,0,'0);
        row(0,0,'0,1,32'h0000_0044,          1,32'hFFFF_FFFC,1,32'h0000_0044);
        row(0,1,32'h0000_0102,0,'0,          1,32'h0000_0000,0,'0);       // wrapped; misaligned target
        row(0,0,'0,1,32'hDEAD_BEEF,          1,32'h0000_0000,0,'0);
        row(0,0,'0,0,'0,                     1,32'h0000_0102,0,'0);

        do_reset();
        foreach (tbl[i]) begin
            @(negedge clk_i);
            stall_i       = tbl[i].stall;
            redirect_i    = tbl[i].redir;
            redirect_pc_i = tbl[i].rpc;
            imem_resp_i   = tbl[i].resp;
            imem_rdata_i  = tbl[i].rdata;
            #1;
            chk($sformatf("row%0d_read", i),  {31'd0, imem_read_o},  {31'd0, tbl[i].e_read});
            chk($sformatf("row%0d_addr", i),  imem_addr_o,           tbl[i].e_addr);
            chk($sformatf("row%0d_pc", i),    pc_o,                  tbl[i].e_addr);
            chk($sformatf("row%0d_valid", i), {31'd0, insn_valid_o}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid)
                chk($sformatf("row%0d_insn", i), insn_o, tbl[i].e_insn);
        end

        // Reset asserted mid-FLUSH, late response ignored.
        @(negedge clk_i);
        stall_i = 0; imem_resp_i = 0;
        redirect_i = 1; redirect_pc_i = 32'h6000_0900;
        #1 chk("mf_redir_valid", {31'd0, insn_valid_o}, 32'd0);
        @(negedge clk_i);
        redirect_i = 0;
        #1;
        chk("mf_flush_read", {31'd0, imem_read_o}, 32'd1);
        chk("mf_flush_addr", imem_addr_o, 32'h0000_0102);
        #2 rst_ni = 1'b0;
        #1;
        chk("mf_rst_read",  {31'd0, imem_read_o},  32'd0);
        chk("mf_rst_addr",  imem_addr_o,           P);
        chk("mf_rst_pc",    pc_o,                  P);
        chk("mf_rst_insn",  insn_o,                32'd0);
        chk("mf_rst_valid", {31'd0, insn_valid_o}, 32'd0);
        @(negedge clk_i);
        imem_resp_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("mf_late_valid", {31'd0, insn_valid_o}, 32'd0);
        @(posedge clk_i);
        #2;
        chk("mf_late_pc", pc_o, P);
        imem_resp_i = 0;
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1 chk("mf_idle_read", {31'd0, imem_read_o}, 32'd0);
        @(posedge clk_i);
        #1;
        chk("mf_first_read", {31'd0, imem_read_o}, 32'd1);
        chk("mf_first_addr", imem_addr_o, P);

        do_reset();
        stream(1, 21, 0);
        do_reset();
        stream(3, 41, 0);
        do_reset();
        stream(2, 300, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the rv32i pipeline. It owns the program counter and issues word reads to instruction memory with a held read/response handshake. It presents `{pc, insn, valid}` to the IF/ID stage register, holds a fetched instruction while the pipeline is stalled, and discards in-flight fetches when a control-flow redirect arrives from a later stage.

## Interface
- `RESET_PC`, default `32'h6000_0000`: PC value after reset.

- `clk_i`  in  1: clock.
- `rst_ni`  in  1: reset; one clock, asynchronous, active-low.
- `stall_i`  in  1: downstream is not accepting; IF/ID is not loading this cycle.
- `redirect_i`  in  1: a taken branch or jump kills the current fetch.
- `redirect_pc_i`  in  32: new fetch target, valid when `redirect_i` is high.
- `imem_read_o`  out  1: instruction-memory read request.
- `imem_addr_o`  out  32: read address; always equals the request PC.
- `imem_resp_i`  in  1: single-cycle pulse; read data is valid.
- `imem_rdata_i`  in  32: read data.
- `pc_o`  out  32: PC of the presented instruction.
- `insn_o`  out  32: presented instruction word.
- `insn_valid_o`  out  1: `pc_o` and `insn_o` are valid this cycle.

## Operation
- State machine `fetch_state_t`: IDLE, FETCH, HOLD, FLUSH. The registers are `state_q`, `pc_q`, `insn_q` and `target_q`.
- IDLE: the reset state. `imem_read_o` is 0. The block moves to FETCH unconditionally on the first clock after reset release.
- FETCH:
  - `imem_read_o` is 1 and `imem_addr_o` is `pc_q`. Both stay stable until `imem_resp_i`.
  - A response with no redirect drives `insn_valid_o` high combinationally, with `insn_o` equal to `imem_rdata_i`.
    - If `stall_i` is 0: `pc_q` becomes `pc_q + 4` (32-bit wrap) and the state stays FETCH.
    - If `stall_i` is 1: `insn_q` captures `imem_rdata_i` and the state moves to HOLD.
- HOLD:
  - `imem_read_o` is 0. `insn_valid_o` is 1 and `insn_o` is `insn_q`.
  - When `stall_i` is 0, `pc_q` becomes `pc_q + 4` and the state moves to FETCH.
- FLUSH:
  - A discarded request is still outstanding. `imem_read_o` stays 1 at the old `pc_q`, and `insn_valid_o` is 0.
  - On `imem_resp_i` the data is dropped, `pc_q` becomes `target_q`, and the state moves to FETCH.
- Redirect priority: `redirect_i` overrides `stall_i` and any response in the same cycle, and `insn_valid_o` is forced to 0 that cycle.
  - FETCH with no response: `target_q` takes `redirect_pc_i` and the state moves to FLUSH.
  - FETCH with a response in the same cycle: `pc_q` takes `redirect_pc_i` and the state stays FETCH.
  - HOLD: the held instruction is dropped, `pc_q` takes `redirect_pc_i`, and the state moves to FETCH.
  - FLUSH with no response: `target_q` takes `redirect_pc_i`, so the latest redirect wins.
  - FLUSH with a response in the same cycle: `pc_q` takes `redirect_pc_i` directly.
  - IDLE: `pc_q` takes `redirect_pc_i`.
- `pc_o` always equals `pc_q`.
- No misalignment check is made; `redirect_pc_i[1:0]` is passed through unchanged.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State is IDLE, `pc_q` is `RESET_PC`, and `insn_q` and `target_q` are 0.
  - Outputs are: `imem_read_o` 0, `imem_addr_o` and `pc_o` equal to `RESET_PC`, `insn_o` 0, `insn_valid_o` 0.
- The first read is asserted on the first cycle after the first clock edge following release.
- Fetch latency from read asserted to `insn_valid_o` equals the memory latency (at least 1 cycle).
- Memory response paths:
  - `imem_resp_i` to `insn_valid_o`/`insn_o` is combinational.
  - Response to the next request is 1 clock: a new address appears the cycle after the response.
  - Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- Control-input paths:
  - `redirect_i` gates `insn_valid_o` combinationally.
  - `stall_i` affects state only, never `insn_valid_o`.
- When `rst_ni` is asserted mid-operation in any state, all registers return to reset values immediately, with no wait for `imem_resp_i`.
  - The memory model must tolerate an abandoned request.

## Structure
- Add `fetch_state_t` (enum) to `rv32i_types`. Use `rv32i_word` for every 32-bit port and register.
- One module with no sub-modules; the PC incrementer is inline.

## Test plan
- Reset and start: hold `rst_ni` low, then release it. Required response: outputs as listed under Timing with `pc_o=32'h6000_0000`; one cycle after release `imem_read_o=1` and `imem_addr_o=32'h6000_0000`.
- Streaming: 1-cycle memory returning `32'h0000_0013`, `stall_i=0`. Required response: `insn_valid_o` pulses every 2nd cycle at addresses 0x6000_0000, 0x6000_0004, 0x6000_0008.
- Stall on response: `stall_i=1` for 3 cycles starting at the response for 0x6000_0004. Required response: HOLD with `insn_o` stable and `insn_valid_o=1` and `imem_read_o=0`; after the stall drops, the next address is 0x6000_0008.
- Redirect in flight: `redirect_i` with target 0x6000_0100 while waiting on 0x6000_0008, then a response of `32'hDEAD_BEEF` 2 cycles later. Required response: `insn_valid_o` stays 0 and the next request is 0x6000_0100.
- Coincident events:
  - Redirect to 0x6000_0200 in the same cycle as a response: `insn_valid_o=0` and the next address is 0x6000_0200.
  - Redirect during HOLD: the held instruction is discarded.
  - Two redirects during FLUSH: the second target is fetched.
- Reset mid-FLUSH: assert `rst_ni` asynchronously between clock edges. Required response: outputs reset immediately, the late response is ignored, and the first fetch after release is 0x6000_0000.
